// File: rtl/rcc_mon_pkg.sv
// Shared types and constants for the ripple-carry-counter sequence monitor.
package rcc_mon_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        RESYNC   = 2'd2
    } mon_state_t;

    localparam int RCC_WIDTH = 4;

endpackage

// File: rtl/rcc_seq_monitor_sat_counter.sv
// Event counter with clear. An increment on the same edge as a clear restarts the count at 1.
module sat_counter #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            if (clr_i) begin
                cnt_d = {{(W-1){1'b0}}, 1'b1};
            end else if (SATURATE && (&cnt_q)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rcc_seq_monitor.sv
// Checks that the upstream counter advances by exactly one per enabled edge; reports wraps and errors.
module rcc_seq_monitor
    import rcc_mon_pkg::*;
#(
    parameter int WIDTH = RCC_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cnt_reset,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             wrap,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic             clr_eff;
    logic             match;

    assign match = (count_in == exp_q);
    // A clear is a state change, so it is ignored on held edges and during upstream reset.
    assign clr_eff = clr_err && en && !cnt_reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= UNLOCKED;
            exp_q    <= '0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (cnt_reset) begin
            state_d = UNLOCKED;
        end else if (en) begin
            exp_d = count_in + 1'b1;
            unique case (state_q)
                UNLOCKED: state_d = LOCKED;
                LOCKED: begin
                    if (match) begin
                        wrap_d = (count_in == '0);
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESYNC;
                    end
                end
                RESYNC: begin
                    // Mismatches here stay silent so one glitch yields one error.
                    if (match) begin
                        state_d = LOCKED;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        if (err_d) begin
            sticky_d = 1'b1;
        end else if (clr_eff) begin
            sticky_d = 1'b0;
        end
    end

    sat_counter #(
        .W        (CNT_W),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (err_d),
        .clr_i  (clr_eff),
        .cnt_o  (err_cnt)
    );

    sat_counter #(
        .W        (CNT_W),
        .SATURATE (1'b0)
    ) u_wrap_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (wrap_d),
        .clr_i  (1'b0),
        .cnt_o  (wrap_cnt)
    );

    always_comb begin
        locked     = (state_q == LOCKED);
        wrap       = wrap_q;
        err        = err_q;
        err_sticky = sticky_q;
    end

endmodule

// File: tb/tb_rcc_seq_monitor.sv
// Directed bench for rcc_seq_monitor with hand-computed expectations.
module tb_rcc_seq_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       cnt_reset;
    logic       clr_err;
    logic [3:0] count_in;
    logic       locked;
    logic       wrap;
    logic [7:0] wrap_cnt;
    logic       err;
    logic       err_sticky;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    rcc_seq_monitor #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cnt_reset  (cnt_reset),
        .clr_err    (clr_err),
        .count_in   (count_in),
        .locked     (locked),
        .wrap       (wrap),
        .wrap_cnt   (wrap_cnt),
        .err        (err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    // Apply inputs at the falling edge, then sample just after the rising edge.
    task automatic drive(input logic e_v, input logic [3:0] v, input logic cr_v,
                         input logic ce_v, input logic rst_v);
        @(negedge clk);
        en        = e_v;
        count_in  = v;
        cnt_reset = cr_v;
        clr_err   = ce_v;
        reset     = rst_v;
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [3:0] v);
        drive(1'b1, v, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int         nwrap;
        int         nerr;
        logic [3:0] e;

        reset = 1'b0; en = 1'b0; cnt_reset = 1'b0; clr_err = 1'b0; count_in = '0;

        // Reset and clean lock
        do_reset();
        chk("rst_locked", locked, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_err", err, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_wrap_cnt", wrap_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        nwrap = 0; nerr = 0;
        for (int i = 0; i < 40; i++) begin
            samp(4'(i % 16));
            if (i == 0) chk("lock_after_first", locked, 1);
            if (i == 16) chk("wrap_pulse_16", wrap, 1);
            if (i == 17) chk("wrap_one_cycle", wrap, 0);
            nwrap += int'(wrap);
            nerr  += int'(err);
        end
        chk("clean_wrap_pulses", nwrap, 2);
        chk("clean_wrap_cnt", wrap_cnt, 2);
        chk("clean_err_pulses", nerr, 0);
        chk("clean_sticky", err_sticky, 0);

        // Single skip: 3,4,6,7,8
        do_reset();
        samp(4'd3);
        samp(4'd4);
        chk("skip_err_before", err, 0);
        samp(4'd6);
        chk("skip_err_pulse", err, 1);
        chk("skip_resync", locked, 0);
        samp(4'd7);
        chk("skip_err_gone", err, 0);
        chk("skip_relock", locked, 1);
        samp(4'd8);
        chk("skip_err_cnt", err_cnt, 1);
        chk("skip_sticky", err_sticky, 1);

        // Upstream reset: 9, then 10 with cnt_reset, then 0,1,2
        samp(4'd9);
        drive(1'b1, 4'd10, 1'b1, 1'b0, 1'b1);
        chk("ureset_unlocked", locked, 0);
        chk("ureset_no_err", err, 0);
        samp(4'd0);
        chk("ureset_relock", locked, 1);
        chk("ureset_no_err2", err, 0);
        samp(4'd1);
        samp(4'd2);
        chk("ureset_no_err3", err, 0);
        chk("ureset_err_cnt", err_cnt, 1);

        // Error storm: one err per entry into RESYNC
        samp(4'd5);
        chk("storm_err", err, 1);
        samp(4'd9);
        chk("storm_quiet1", err, 0);
        samp(4'd12);
        chk("storm_quiet2", err, 0);
        samp(4'd13);
        chk("storm_quiet3", err, 0);
        chk("storm_relock", locked, 1);
        chk("storm_err_cnt", err_cnt, 2);

        // Saturation: 300 mismatch/match pairs
        e = 4'd14; nerr = 0; nwrap = 0;
        for (int i = 0; i < 300; i++) begin
            samp(e + 4'd5);
            nerr  += int'(err);
            nwrap += int'(wrap);
            e = e + 4'd6;
            samp(e);
            nerr  += int'(err);
            nwrap += int'(wrap);
            e = e + 4'd1;
        end
        chk("sat_err_pulses", nerr, 300);
        chk("sat_no_wrap", nwrap, 0);
        chk("sat_err_cnt", err_cnt, 255);
        samp(e + 4'd2);
        chk("sat_err_still_pulses", err, 1);
        chk("sat_err_cnt_hold", err_cnt, 255);
        e = e + 4'd3;
        samp(e);
        e = e + 4'd1;
        chk("sat_relock", locked, 1);

        // clr_err collides with a mismatch: error wins
        drive(1'b1, e + 4'd3, 1'b0, 1'b1, 1'b1);
        chk("clr_coll_err", err, 1);
        chk("clr_coll_cnt", err_cnt, 1);
        chk("clr_coll_sticky", err_sticky, 1);
        e = e + 4'd4;
        drive(1'b1, e, 1'b0, 1'b1, 1'b1);
        chk("clr_alone_cnt", err_cnt, 0);
        chk("clr_alone_sticky", err_sticky, 0);

        // en gaps and mid-run reset
        do_reset();
        samp(4'd4);
        samp(4'd5);
        drive(1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
        chk("gap_no_err1", err, 0);
        chk("gap_locked1", locked, 1);
        drive(1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
        chk("gap_no_err2", err, 0);
        samp(4'd6);
        chk("gap_no_err3", err, 0);
        chk("gap_locked2", locked, 1);
        samp(4'd7);
        samp(4'd11);
        chk("gap_err_before_reset", err_cnt, 1);
        drive(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        chk("midrst_locked", locked, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_sticky", err_sticky, 0);
        chk("midrst_wrap_cnt", wrap_cnt, 0);
        chk("midrst_err", err, 0);
        samp(4'd3);
        chk("midrst_capture_lock", locked, 1);
        chk("midrst_capture_no_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rcc_seq_monitor.md
# rcc_seq_monitor

Sequence monitor placed directly downstream of the 4-bit ripple carry counter. It samples the counter's `q` on every enabled `clk` rising edge and checks that each value is the previous value plus one, modulo 2^WIDTH. It reports one-cycle wrap and error pulses, a sticky error flag, and wrap and error counters for the status logic and the bench. The upstream counter updates on the falling edge, so the `q` value sampled on the rising edge is always settled.

## Interface
- `WIDTH`, 4: width of the monitored count.
- `CNT_W`, 8: width of `wrap_cnt` and `err_cnt`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the `clk` rising edge; 0 resets all state.
- `en` input 1: 1 means sample and check `count_in` this edge; 0 means hold all state.
- `cnt_reset` input 1: upstream counter is being reset. Drops lock without flagging an error.
- `clr_err` input 1: clears `err_sticky` and `err_cnt`.
- `count_in` input WIDTH: the counter value `q`.
- `locked` output 1: high while in LOCKED.
- `wrap` output 1: one-cycle pulse on a checked wrap from 2^WIDTH-1 to 0.
- `wrap_cnt` output CNT_W: free-running wrap count, wraps modulo 2^CNT_W.
- `err` output 1: one-cycle pulse on a sequence mismatch detected in LOCKED.
- `err_sticky` output 1: set by `err`, held until `clr_err` or reset.
- `err_cnt` output CNT_W: error count, saturates at 2^CNT_W-1.

## Operation
- **State register.** States are UNLOCKED, LOCKED and RESYNC. `exp` is a WIDTH-bit expected-value register; `exp` arithmetic wraps modulo 2^WIDTH.
- **Reset** (`reset`=0). State goes to UNLOCKED; `exp`=0. All outputs are 0.
- **Priority, per edge.** `reset`, then `cnt_reset`, then `en`. When `en`=0 there is no state change, no pulse, and all counters hold.
- **`cnt_reset`=1.** Go to UNLOCKED, regardless of `en`. No `err`. Counters are unchanged.
- **UNLOCKED, `en`=1.** Set `exp`=`count_in`+1 and go to LOCKED. This first sample is never checked.
- **LOCKED, `en`=1, `count_in`==`exp`.**
  - `exp`=`count_in`+1.
  - If `count_in`==0, pulse `wrap` and increment `wrap_cnt`.
- **LOCKED, `en`=1, mismatch.**
  - Pulse `err`, set `err_sticky`, increment `err_cnt` (saturating).
  - `exp`=`count_in`+1; go to RESYNC.
- **RESYNC, `en`=1.**
  - Match: go to LOCKED.
  - Mismatch: stay in RESYNC with no further `err`; this prevents error storms.
  - In both cases `exp`=`count_in`+1.
  - `wrap` is never counted in RESYNC.
- **`clr_err`.** `err_sticky` goes to 0 and `err_cnt` goes to 0.
- **`clr_err` and a new error on the same edge.** The error wins: `err_sticky`=1 and `err_cnt`=1.

## Timing
- All outputs are registered.
- Latency is 1 cycle: a sample taken on edge N produces `err`, `wrap` and updated counters/`locked` in the cycle after edge N.
- `err` and `wrap` are high for exactly one cycle per event. They are never high in the cycle after an edge with `en`=0.
- `err` and `wrap` are mutually exclusive within one cycle.
- Reset mid-operation clears everything on that edge. The first sample after reset is the UNLOCKED capture.
- Saturation: with `err_cnt`=2^CNT_W-1, a further error still pulses `err`, and `err_cnt` holds.
- Combinational paths: `count_in` to next-state, through one WIDTH-bit incrementer and comparator only.

## Structure
- **Package `rcc_mon_pkg`.**
  - `typedef enum logic [1:0] {UNLOCKED, LOCKED, RESYNC} mon_state_t`.
  - `localparam RCC_WIDTH = 4`.
- **Sub-module `sat_counter`** (parameters `W` and `SATURATE`). It provides increment, clear, and increment-beats-clear priority. It is instantiated twice:
  - `err_cnt` with `SATURATE`=1.
  - `wrap_cnt` with `SATURATE`=0.
- **Top module.** Holds the FSM, `exp`, and the pulse registers.

## Test plan
All scenarios use WIDTH=4 and CNT_W=8.
- **Reset and clean lock.** Hold `reset`=0 for 2 edges, then run the counter from 0 for 40 enabled edges (0 to 15 to 0 …). Required response:
  - `locked`=1 one cycle after the first sample.
  - `wrap` pulses exactly twice; `wrap_cnt`=2.
  - `err` is never asserted; `err_sticky`=0.
- **Single skip.** Drive 3,4,6,7,8. Required response:
  - `err` pulses once, in the cycle after the sample of 6.
  - RESYNC on 6; LOCKED again after 7.
  - `err_cnt`=1, `err_sticky`=1.
- **Upstream reset.** Drive 9,10 with `cnt_reset`=1, then 0,1,2. Required response:
  - No `err`.
  - `locked`=0 for one cycle, then 1.
  - `err_cnt` is unchanged.
- **Error storm and saturation.** Drive alternating mismatches. Required response:
  - Only one `err` per entry into RESYNC.
  - Force 300 LOCKED mismatches, each followed by a match. `err_cnt` holds at 255 while `err` still pulses.
- **`clr_err` collision.** Assert `clr_err` on the same edge as a mismatch. Required response: `err_cnt`=1 and `err_sticky`=1. `clr_err` alone gives 0 and 0.
- **`en` gaps and mid-run reset.** Drive 5 (`en`=1), 6 (`en`=0), 9 (`en`=0), 6 (`en`=1). Required response:
  - No `err`; gaps hold state.
  - A `reset`=0 pulse at `count_in`=12 gives `locked`=0, all counters 0, and UNLOCKED on the next sample.
